// File: rtl/barrel_shift_arbiter.sv
// barrel_shift_arbiter: round-robin sharing of one registered 8-bit barrel shifter with id-tagged responses
module barrel_shift_arbiter #(
    parameter int NREQ      = 4,
    parameter int SHIFT_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*8-1:0] x_flat,
    input  logic [NREQ*4-1:0] shift_flat,
    output logic [NREQ-1:0]   gnt,
    output logic [7:0]        sh_x,
    output logic [3:0]        sh_n,
    input  logic [7:0]        sh_y,
    output logic              rsp_valid,
    output logic [1:0]        rsp_id,
    output logic [7:0]        rsp_data,
    output logic              busy
);
    logic [NREQ-1:0] gnt_q, gnt_d, elig;
    logic [7:0] sh_x_q, sh_x_d, rsp_data_q, rsp_data_d;
    logic [3:0] sh_n_q, sh_n_d;
    logic [1:0] ptr_q, ptr_d, win, rsp_id_q, rsp_id_d;
    logic win_v, rsp_valid_q, rsp_valid_d;
    logic [SHIFT_LAT:0] tag_v_q, tag_v_d;
    logic [SHIFT_LAT:0][1:0] tag_id_q, tag_id_d;
    int idx;
    // The requester granted last cycle is masked so a late req drop never double-grants.
    always_comb begin
        elig  = req & ~gnt_q;
        win_v = 1'b0;
        win   = ptr_q;
        idx   = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (elig[idx]) begin
                win_v = 1'b1;
                win   = idx[1:0];
            end
        end
        gnt_d       = win_v ? ({{(NREQ-1){1'b0}}, 1'b1} << win) : '0;
        sh_x_d      = win_v ? x_flat[8*win +: 8] : sh_x_q;
        sh_n_d      = win_v ? shift_flat[4*win +: 4] : sh_n_q;
        ptr_d       = win_v ? ((int'(win) == NREQ - 1) ? 2'd0 : win + 2'd1) : ptr_q;
        tag_v_d     = {tag_v_q[SHIFT_LAT-1:0], win_v};
        tag_id_d    = {tag_id_q[SHIFT_LAT-1:0], win};
        rsp_valid_d = tag_v_q[SHIFT_LAT];
        rsp_id_d    = tag_v_q[SHIFT_LAT] ? tag_id_q[SHIFT_LAT] : rsp_id_q;
        rsp_data_d  = tag_v_q[SHIFT_LAT] ? sh_y : rsp_data_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_q       <= '0;
            sh_x_q      <= '0;
            sh_n_q      <= '0;
            ptr_q       <= '0;
            tag_v_q     <= '0;
            tag_id_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            gnt_q       <= gnt_d;
            sh_x_q      <= sh_x_d;
            sh_n_q      <= sh_n_d;
            ptr_q       <= ptr_d;
            tag_v_q     <= tag_v_d;
            tag_id_q    <= tag_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end
    assign gnt       = gnt_q;
    assign sh_x      = sh_x_q;
    assign sh_n      = sh_n_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = |gnt_q | |tag_v_q | rsp_valid_q;
endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// tb_barrel_shift_arbiter: directed test of barrel_shift_arbiter against a registered rotate-left stub shifter
module tb_barrel_shift_arbiter;
    logic clk = 1'b0, rst = 1'b1;
    logic [3:0] req = '0;
    logic [31:0] x_flat = '0;
    logic [15:0] shift_flat = '0;
    logic [3:0] gnt;
    logic [7:0] sh_x, sh_y, rsp_data;
    logic [3:0] sh_n;
    logic rsp_valid, busy;
    logic [1:0] rsp_id;
    logic [15:0] rot;
    int total = 0, bad = 0;
    logic [7:0] sweep_exp [8] = '{8'h1A, 8'h34, 8'h68, 8'hD0, 8'hA1, 8'h43, 8'h86, 8'h0D};
    logic [7:0] rr_exp [4] = '{8'h22, 8'h88, 8'h99, 8'h44};

    barrel_shift_arbiter #(.NREQ(4), .SHIFT_LAT(1)) dut (
        .clk(clk), .rst(rst), .req(req), .x_flat(x_flat), .shift_flat(shift_flat),
        .gnt(gnt), .sh_x(sh_x), .sh_n(sh_n), .sh_y(sh_y),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
    );

    always #5 clk = ~clk;
    assign rot = {sh_x, sh_x} << sh_n[2:0];
    always_ff @(posedge clk) sh_y <= rot[15:8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".gnt"}, 32'(gnt), 0);
        chk({tag, ".sh_x"}, 32'(sh_x), 0);
        chk({tag, ".sh_n"}, 32'(sh_n), 0);
        chk({tag, ".rsp_valid"}, 32'(rsp_valid), 0);
        chk({tag, ".rsp_id"}, 32'(rsp_id), 0);
        chk({tag, ".rsp_data"}, 32'(rsp_data), 0);
        chk({tag, ".busy"}, 32'(busy), 0);
    endtask

    task automatic do_op(input int i, input logic [7:0] x, input logic [3:0] n, input logic [7:0] exp_d);
        req = 4'(1 << i);
        x_flat[8*i +: 8] = x;
        shift_flat[4*i +: 4] = n;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            if (gnt[i]) break;
        end
        chk("op.gnt", 32'(gnt), 32'(1 << i));
        chk("op.sh_x", 32'(sh_x), 32'(x));
        chk("op.sh_n", 32'(sh_n), 32'(n));
        req = '0;
        @(negedge clk);
        chk("op.gap_valid", 32'(rsp_valid), 0);
        @(negedge clk);
        chk("op.rsp_valid", 32'(rsp_valid), 1);
        chk("op.rsp_id", 32'(rsp_id), 32'(i));
        chk("op.rsp_data", 32'(rsp_data), 32'(exp_d));
    endtask

    initial begin
        @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        do_op(0, 8'h1A, 4'd3, 8'hD0);
        for (int n = 0; n < 8; n++) do_op(2, 8'h1A, 4'(n), sweep_exp[n]);
        // All four requesting from a fresh pointer
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        x_flat = {8'h44, 8'h33, 8'h22, 8'h11};
        shift_flat = {4'd4, 4'd3, 4'd2, 4'd1};
        req = 4'hF;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            chk("rr.gnt", 32'(gnt), 32'(1 << ((c - 1) % 4)));
            chk("rr.busy", 32'(busy), 1);
            if (c >= 3) begin
                chk("rr.rsp_valid", 32'(rsp_valid), 1);
                chk("rr.rsp_id", 32'(rsp_id), 32'((c - 3) % 4));
                chk("rr.rsp_data", 32'(rsp_data), 32'(rr_exp[(c - 3) % 4]));
            end
        end
        req = '0;
        repeat (3) @(negedge clk);
        req = 4'b1000;
        @(negedge clk);
        chk("wrap.g3", 32'(gnt), 32'h8);
        req = 4'b1001;
        @(negedge clk);
        chk("wrap.g0", 32'(gnt), 32'h1);
        @(negedge clk);
        chk("wrap.g3b", 32'(gnt), 32'h8);
        req = '0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk("idle.gnt", 32'(gnt), 0);
            chk("idle.sh_x", 32'(sh_x), 32'h44);
            chk("idle.sh_n", 32'(sh_n), 4);
            chk("idle.busy", 32'(busy), (k <= 2) ? 1 : 0);
        end
        req = 4'b0011;
        @(negedge clk);
        chk("mid.g0", 32'(gnt), 32'h1);
        @(negedge clk);
        chk("mid.g1", 32'(gnt), 32'h2);
        req = '0;
        #2 rst = 1'b1;
        #1 chk_zero("async_rst");
        @(negedge clk);
        chk("rst.no_rsp1", 32'(rsp_valid), 0);
        req = 4'b0110;
        @(negedge clk);
        chk("rst.no_rsp2", 32'(rsp_valid), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rel.gnt", 32'(gnt), 32'h2);
        chk("rel.no_rsp", 32'(rsp_valid), 0);
        req = '0;
        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/barrel_shift_arbiter.md
Name: barrel_shift_arbiter

Overview:
- Round-robin arbiter that shares one registered 8-bit barrel shifter among NREQ requesters.
- Captures each requester's operand and shift amount on grant and drives them onto the shifter inputs.
- Tracks in-flight operations through the shifter latency and returns each result tagged with the requester ID.
- Sits between the requester blocks and the shared barrelShift instance. Issue rate is one operation per clock.

Parameters:
NREQ, 4, number of requesters (2..4); ID width fixed at 2 bits
SHIFT_LAT, 1, clocks from shifter input valid to sh_y valid (registered shifter = 1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
req  input  NREQ  per-requester request, level, held until granted
x_flat  input  NREQ*8  operand of requester i at bits [8i+7:8i]
shift_flat  input  NREQ*4  shift amount of requester i at bits [4i+3:4i]
gnt  output  NREQ  one-hot, one-cycle grant pulse, registered
sh_x  output  8  operand to shifter, registered
sh_n  output  4  shift amount to shifter, registered
sh_y  input  8  shifter result
rsp_valid  output  1  one-cycle result strobe, registered
rsp_id  output  2  requester index of the result
rsp_data  output  8  result, equals sh_y of that operation
busy  output  1  high while any grant or operation is in flight

Behaviour:
- Reset: gnt=0, sh_x=0, sh_n=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0, RR pointer=0, tag pipeline cleared. Reset is asynchronous and takes effect immediately.
- Arbitration, each edge: eligible = req & ~gnt.
  - Requester whose gnt is currently high is masked, so a requester dropping req on the edge after its grant is never double-granted.
  - Winner = first eligible index at or after the pointer, searching upward with wrap.
  - On a win: gnt[winner]<=1, sh_x/sh_n <= winner's slices, pointer <= (winner+1) mod NREQ.
  - No eligible requester: gnt<=0; sh_x/sh_n hold their last value; pointer unchanged.
- Issue cycle: the cycle in which gnt is high; sh_x/sh_n are valid during that cycle.
- Requester protocol:
  - Keep req and data stable until the edge at which gnt is seen high.
  - May re-raise req from the following cycle; it becomes eligible one cycle later because of the mask.
- Tag pipeline: depth SHIFT_LAT+1, entries are {valid, id}. Injected at each issue with the winner's id.
- Response: rsp_valid pulses in cycle issue+SHIFT_LAT+1.
  - rsp_data is registered from sh_y sampled SHIFT_LAT cycles after issue.
  - rsp_id is registered from the matching tag.
  - Back-to-back issues produce back-to-back responses in issue order.
  - No backpressure: consumers must accept every rsp_valid.
- Shift amounts 8..15 are passed unchanged; their meaning belongs to the shifter.
- busy = |gnt | any tag-pipeline valid | rsp_valid.
- Fairness: with all requesters continuously requesting, the grant order is 0,1,2,3,0,... Max wait is NREQ-1 grants.
- Reset mid-operation: all in-flight tags are dropped and no rsp_valid is produced for them. The first grant after reset release goes to the lowest requesting index.
- Simultaneous req rise on several lines: resolved by the pointer only; there is no fixed priority.

Test Plan:
- Single op, TB stub shifter = registered rotate-left, SHIFT_LAT=1: req[0]=1, x=8'h1A, n=3 -> gnt[0] pulse one cycle after req is sampled; sh_x=8'h1A, sh_n=3 in that cycle; two cycles later rsp_valid=1, rsp_id=0, rsp_data=8'hD0.
- Sweep: requester 2, x=8'b00011010, n=0..7 issued sequentially -> responses 1A,34,68,D0,A1,43,86,0D in order, all with rsp_id=2.
- All four requesters held high with distinct x -> gnt sequence 1,2,4,8,1,... and one issue per cycle. Back-to-back responses carry ids 0,1,2,3,0 with matching data. No requester is granted twice in consecutive cycles.
- Pointer wrap: grant requester 3, then only requesters 0 and 3 requesting -> next grant goes to 0, then 3.
- Reset asserted asynchronously while two ops are in flight -> all outputs read 0 within the reset cycle and no rsp_valid occurs afterward. After release with req=4'b0110, the first grant is gnt=4'b0010.
- Idle: req=0 for 10 cycles after traffic -> gnt=0, busy falls SHIFT_LAT+2 cycles after the last grant, sh_x/sh_n hold their last values.
